bp_me_dma_mem_responder: RTL

BP_ME_DMA_MEM_RESPONDER -- requirements
Module: bp_me_dma_mem_responder

---
 rtl/bp_me_dma_mem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bp_me_dma_mem_responder.sv
// Single-port memory responder for BedRock memory commands. Services reads and writes against a
// local word-addressed backing store and echoes every accepted header back as its response.
// Header layout (LSB first): msg_type[3:0], size[6:4], addr[7 +: paddr_width_p], payload in the remaining MSBs.
module bp_me_dma_mem_responder #(
  parameter int paddr_width_p  = 40,
  parameter int data_width_p   = 64,
  parameter int mem_els_p      = 1024,
  parameter int header_width_p = 4 + 3 + paddr_width_p + 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [header_width_p-1:0] mem_cmd_header_i,
  input  logic                      mem_cmd_header_v_i,
  output logic                      mem_cmd_header_yumi_o,

  input  logic [data_width_p-1:0]   mem_cmd_data_i,
  input  logic                      mem_cmd_data_v_i,
  output logic                      mem_cmd_data_yumi_o,

  output logic [header_width_p-1:0] mem_resp_header_o,
  output logic                      mem_resp_header_v_o,
  input  logic                      mem_resp_header_ready_i,

  output logic [data_width_p-1:0]   mem_resp_data_o,
  output logic                      mem_resp_data_v_o,
  input  logic                      mem_resp_data_ready_i
);

  localparam int lg_beat_bytes_lp = $clog2(data_width_p / 8);
  localparam int lg_els_lp        = $clog2(mem_els_p);
  localparam int lg_max_beats_lp  = (7 > lg_beat_bytes_lp) ? (7 - lg_beat_bytes_lp) : 0;
  localparam int cnt_width_lp     = (lg_max_beats_lp > 0) ? lg_max_beats_lp : 1;
  localparam int addr_lsb_lp      = 7;

  localparam logic [3:0] mem_rd_lp    = 4'd0;
  localparam logic [3:0] mem_wr_lp    = 4'd1;
  localparam logic [3:0] mem_uc_rd_lp = 4'd2;
  localparam logic [3:0] mem_uc_wr_lp = 4'd3;

  typedef enum logic [1:0] {
    e_ready,
    e_write_data,
    e_resp_header,
    e_read_data
  } state_e;

  state_e                    state_q, state_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
  logic [header_width_p-1:0] hdr_q, hdr_d;
  logic                      out_en_q, out_en_d;

  logic [3:0]                msg_type;
  logic [3:0]                in_type;
  logic [2:0]                size;
  logic [2:0]                lg_n;
  logic [lg_els_lp-1:0]      start_idx;
  logic [lg_els_lp-1:0]      win_mask;
  logic [lg_els_lp-1:0]      beat_idx;
  logic                      last_beat;
  logic                      out_en;
  logic                      is_rd;

  assign msg_type  = hdr_q[3:0];
  assign size      = hdr_q[6:4];
  assign in_type   = mem_cmd_header_i[3:0];
  assign start_idx = hdr_q[addr_lsb_lp + lg_beat_bytes_lp +: lg_els_lp];
  assign is_rd     = (msg_type == mem_rd_lp) || (msg_type == mem_uc_rd_lp);

  // Transfers narrower than one beat still move a single full word.
  assign lg_n      = (size > 3'(lg_beat_bytes_lp)) ? (size - 3'(lg_beat_bytes_lp)) : 3'd0;
  assign win_mask  = lg_els_lp'((32'd1 << lg_n) - 32'd1);
  assign last_beat = (cnt_q == cnt_width_lp'((32'd1 << lg_n) - 32'd1));

  // Critical-word-first: only the low log2(N) index bits advance, and they wrap inside the window.
  assign beat_idx  = (start_idx & ~win_mask) | ((start_idx + lg_els_lp'(cnt_q)) & win_mask);

  // Handshake outputs stay quiet during reset and for one cycle after it.
  assign out_en    = out_en_q & ~reset_i;

  logic [data_width_p-1:0] mem_q [mem_els_p];

  always_ff @(posedge clk_i) begin
    if (mem_cmd_data_yumi_o) begin
      mem_q[beat_idx] <= mem_cmd_data_i;
    end
  end

  assign mem_resp_data_o   = mem_q[beat_idx];
  assign mem_resp_header_o = hdr_q;

  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    hdr_d                 = hdr_q;
    out_en_d              = 1'b1;
    mem_cmd_header_yumi_o = 1'b0;
    mem_cmd_data_yumi_o   = 1'b0;
    mem_resp_header_v_o   = 1'b0;
    mem_resp_data_v_o     = 1'b0;

    unique case (state_q)
      e_ready: begin
        mem_cmd_header_yumi_o = out_en & mem_cmd_header_v_i;
        if (mem_cmd_header_yumi_o) begin
          hdr_d   = mem_cmd_header_i;
          cnt_d   = '0;
          state_d = ((in_type == mem_wr_lp) || (in_type == mem_uc_wr_lp)) ? e_write_data : e_resp_header;
        end
      end

      e_write_data: begin
        mem_cmd_data_yumi_o = out_en & mem_cmd_data_v_i;
        if (mem_cmd_data_yumi_o) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = e_resp_header;
          end
        end
      end

      e_resp_header: begin
        mem_resp_header_v_o = out_en;
        if (mem_resp_header_v_o && mem_resp_header_ready_i) begin
          cnt_d   = '0;
          state_d = is_rd ? e_read_data : e_ready;
        end
      end

      e_read_data: begin
        mem_resp_data_v_o = out_en;
        if (mem_resp_data_v_o && mem_resp_data_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = e_ready;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_ready;
      cnt_q    <= '0;
      hdr_q    <= '0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      out_en_q <= out_en_d;
    end
  end

endmodule
